// File: rtl/defines.v
// Shared register-file widths and write-enable encodings used by the writeback path.
`ifndef REGFILE_DEFINES_V
`define REGFILE_DEFINES_V
`define RegAddrBus  4:0
`define RegBus      31:0
`define RegNum      32
`define ZeroWord    32'h00000000
`define WriteEnable 1'b1
`define WriteDisable 1'b0
`define WbSrcWidth  1
`endif

// File: rtl/wb_slot.sv
// One-entry writeback buffer: captures a request, clears when drained, wiped by flush.
`ifndef REGFILE_DEFINES_V
`include "defines.v"
`endif

module wb_slot (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [`RegAddrBus] addr_i,
  input  logic [`RegBus]     data_i,
  output logic               vld_o,
  output logic [`RegAddrBus] addr_o,
  output logic [`RegBus]     data_o
);
  logic               vld_q, vld_d;
  logic [`RegAddrBus] addr_q, addr_d;
  logic [`RegBus]     data_q, data_d;

  // A load in the same cycle as a clear reloads the slot rather than emptying it.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d  = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end else if (clear_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= `ZeroWord;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges execute and load writebacks into the single register-file write port,
// oldest-first, with per-register pending flags for hazard detection.
`ifndef REGFILE_DEFINES_V
`include "defines.v"
`endif

module regfile_wb_arbiter (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [`RegAddrBus] ex_waddr,
  input  logic [`RegBus]     ex_wdata,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [`RegAddrBus] mem_waddr,
  input  logic [`RegBus]     mem_wdata,
  output logic               we,
  output logic [`RegAddrBus] waddr,
  output logic [`RegBus]     wdata,
  output logic [`RegNum-1:0] busy
);
  localparam logic [`WbSrcWidth-1:0] SRC_EX  = 1'b0;
  localparam logic [`WbSrcWidth-1:0] SRC_MEM = 1'b1;

  logic               ex_vld, mem_vld;
  logic [`RegAddrBus] ex_addr, mem_addr;
  logic [`RegBus]     ex_data, mem_data;
  logic               gnt_ex, gnt_mem;
  logic               ex_cap, mem_cap;
  logic [`WbSrcWidth-1:0] wb_src;
  // age_q = 1: ex buffer was captured before mem buffer.
  logic               age_q, age_d;

  always_comb begin
    gnt_ex  = 1'b0;
    gnt_mem = 1'b0;
    if (!flush) begin
      if (ex_vld && mem_vld) begin
        gnt_ex  = age_q;
        gnt_mem = !age_q;
      end else begin
        gnt_ex  = ex_vld;
        gnt_mem = mem_vld;
      end
    end
  end

  assign ex_ready  = rst && (flush || !ex_vld  || gnt_ex);
  assign mem_ready = rst && (flush || !mem_vld || gnt_mem);

  // Address-0 handshakes complete but never occupy a buffer.
  assign ex_cap  = ex_valid  && ex_ready  && (|ex_waddr)  && !flush;
  assign mem_cap = mem_valid && mem_ready && (|mem_waddr) && !flush;

  wb_slot u_ex_slot (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .load_i  (ex_cap),
    .clear_i (gnt_ex),
    .addr_i  (ex_waddr),
    .data_i  (ex_wdata),
    .vld_o   (ex_vld),
    .addr_o  (ex_addr),
    .data_o  (ex_data)
  );

  wb_slot u_mem_slot (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .load_i  (mem_cap),
    .clear_i (gnt_mem),
    .addr_i  (mem_waddr),
    .data_i  (mem_wdata),
    .vld_o   (mem_vld),
    .addr_o  (mem_addr),
    .data_o  (mem_data)
  );

  // A freshly captured buffer is always the younger one; a tie leaves mem older.
  always_comb begin
    age_d = age_q;
    if (flush)                  age_d = 1'b0;
    else if (ex_cap)            age_d = 1'b0;
    else if (mem_cap)           age_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) age_q <= 1'b0;
    else      age_q <= age_d;
  end

  assign wb_src = gnt_mem ? SRC_MEM : SRC_EX;
  assign we     = (gnt_ex || gnt_mem) ? `WriteEnable : `WriteDisable;

  always_comb begin
    waddr = '0;
    wdata = `ZeroWord;
    if (we) begin
      waddr = (wb_src == SRC_MEM) ? mem_addr : ex_addr;
      wdata = (wb_src == SRC_MEM) ? mem_data : ex_data;
    end
  end

  assign busy[0] = 1'b0;
  for (genvar i = 1; i < `RegNum; i++) begin : g_busy
    assign busy[i] = (ex_vld  && (int'(ex_addr)  == i)) ||
                     (mem_vld && (int'(mem_addr) == i));
  end
endmodule
